// File: rtl/jts16_pcm_rom_arb.sv
// Two 8-bit readers, each with a one-entry read cache, sharing one SDRAM PCM ROM slot.
// Define JTS16_PCMARB_TIMEOUT_EN to abort a stuck slot read and return 0xFF after TIMEOUT wait cycles.
module jts16_pcm_rom_arb #(
  parameter int AW      = 17,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [AW-1:0] a_addr,
  input  logic          a_cs,
  output logic [7:0]    a_data,
  output logic          a_ok,
  input  logic [AW-1:0] b_addr,
  input  logic          b_cs,
  output logic [7:0]    b_data,
  output logic          b_ok,
  output logic [AW-1:0] slot_addr,
  output logic          slot_cs,
  input  logic [7:0]    slot_data,
  input  logic          slot_ok
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  state_t        state, state_nx;
  logic [AW-1:0] tag [2];
  logic [7:0]    dat [2];
  logic [1:0]    valid;
  logic [1:0]    hit, pend;
  logic          gnt, gnt_nx, last, flushed;
  logic          grant, fill, timed_out;
  logic [7:0]    fill_dat;

  assign hit[0] = a_cs & valid[0] & (a_addr == tag[0]);
  assign hit[1] = b_cs & valid[1] & (b_addr == tag[1]);
  assign pend   = {b_cs, a_cs} & ~hit;

  assign a_ok   = hit[0];
  assign a_data = dat[0];
  assign b_ok   = hit[1];
  assign b_data = dat[1];

`ifdef JTS16_PCMARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;

  assign timed_out = (state == WAIT) && !slot_ok && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (grant)          wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gnt_nx   = gnt;
    fill     = 1'b0;
    fill_dat = slot_data;
    unique case (state)
      IDLE: begin
        // on a tie, the requester that did not win last time goes first
        if (pend[0] && (!pend[1] || last == REQ_B)) begin
          grant  = 1'b1;
          gnt_nx = REQ_A;
        end else if (pend[1]) begin
          grant  = 1'b1;
          gnt_nx = REQ_B;
        end
        if (grant) state_nx = ISSUE;
      end
      // slot_ok may still belong to the previous address here
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (slot_ok || timed_out) begin
          fill     = 1'b1;
          fill_dat = slot_ok ? slot_data : 8'hFF;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the two cache entries are plain registers, not RAM, so they are reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tag[0]    <= '0;
      tag[1]    <= '0;
      dat[0]    <= '0;
      dat[1]    <= '0;
      valid     <= '0;
      gnt       <= REQ_A;
      last      <= REQ_B;
      flushed   <= 1'b0;
      slot_addr <= '0;
      slot_cs   <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        slot_addr <= (gnt_nx == REQ_B) ? b_addr : a_addr;
        slot_cs   <= 1'b1;
        gnt       <= gnt_nx;
        last      <= gnt_nx;
        flushed   <= 1'b0;
      end else if (flush && state != IDLE) begin
        flushed <= 1'b1;
      end
      // a fill that overlaps a flush stores the data but stays invalid
      if (fill) begin
        tag[gnt]   <= slot_addr;
        dat[gnt]   <= fill_dat;
        valid[gnt] <= ~(flushed | flush);
        slot_cs    <= 1'b0;
      end
      if (flush) valid <= '0;
    end
  end

endmodule

// File: tb/tb_jts16_pcm_rom_arb.sv
// Bench for jts16_pcm_rom_arb: transaction-level cache/arbiter model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_jts16_pcm_rom_arb;
  localparam int AW      = 17;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic          a_cs = 1'b0, b_cs = 1'b0;
  logic [7:0]    a_data, b_data, slot_data;
  logic          a_ok, b_ok, slot_cs, slot_ok;
  logic [AW-1:0] slot_addr;

  jts16_pcm_rom_arb #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a_addr(a_addr), .a_cs(a_cs), .a_data(a_data), .a_ok(a_ok),
    .b_addr(b_addr), .b_cs(b_cs), .b_data(b_data), .b_ok(b_ok),
    .slot_addr(slot_addr), .slot_cs(slot_cs), .slot_data(slot_data), .slot_ok(slot_ok)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'h3E, a[16]};
  endfunction

  // SDRAM slot responder
  int delay    = 2;
  bit force_ok = 1'b0;
  bit no_ok    = 1'b0;
  int rcnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rcnt <= 0;
    else        rcnt <= slot_cs ? rcnt + 1 : 0;
  assign slot_ok   = force_ok || (slot_cs && !no_ok && rcnt >= delay);
  assign slot_data = rom(slot_addr);

  // Model: two caches and one outstanding transaction with an age in cycles
  logic [AW-1:0] m_tag [2];
  logic [7:0]    m_dat [2];
  bit            m_valid [2];
  bit            m_busy, m_flushed;
  int            m_gnt, m_last, m_age;
  logic [AW-1:0] m_addr;
  bit            pa, pb, mfill;
  logic [7:0]    mfd;

  task automatic m_start(input int g, input logic [AW-1:0] addr);
    m_busy = 1; m_gnt = g; m_addr = addr; m_age = 0; m_last = g; m_flushed = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin m_tag[i] = '0; m_dat[i] = '0; m_valid[i] = 0; end
      m_busy = 0; m_flushed = 0; m_gnt = 0; m_last = 1; m_age = 0; m_addr = '0;
    end else begin
      pa = a_cs && !(m_valid[0] && a_addr == m_tag[0]);
      pb = b_cs && !(m_valid[1] && b_addr == m_tag[1]);
      mfill = 0;
      mfd   = 8'h00;
      if (!m_busy) begin
        if (pa && (!pb || m_last == 1)) m_start(0, a_addr);
        else if (pb)                    m_start(1, b_addr);
      end else begin
        if (m_age > 0 && slot_ok) begin mfill = 1; mfd = rom(m_addr); end
`ifdef JTS16_PCMARB_TIMEOUT_EN
        else if (m_age == TIMEOUT) begin mfill = 1; mfd = 8'hFF; end
`endif
        if (mfill) begin
          m_tag[m_gnt]   = m_addr;
          m_dat[m_gnt]   = mfd;
          m_valid[m_gnt] = !(m_flushed || flush);
          m_busy         = 0;
        end else begin
          m_age++;
        end
        if (flush) m_flushed = 1;
      end
      if (flush) begin m_valid[0] = 0; m_valid[1] = 0; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_a_ok",      a_ok,      a_cs && m_valid[0] && a_addr == m_tag[0]);
      check("cmp_a_data",    a_data,    m_dat[0]);
      check("cmp_b_ok",      b_ok,      b_cs && m_valid[1] && b_addr == m_tag[1]);
      check("cmp_b_data",    b_data,    m_dat[1]);
      check("cmp_slot_cs",   slot_cs,   m_busy);
      check("cmp_slot_addr", slot_addr, m_addr);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_cs = 1'b0; b_cs = 1'b0; flush = 1'b0; force_ok = 1'b0; no_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string name);
    int n = 0;
    while (slot_cs !== lvl && n < budget) begin tick(); n++; end
    check(name, slot_cs, lvl);
  endtask

  task automatic wait_a_ok(input int budget, input string name);
    int n = 0;
    while (a_ok !== 1'b1 && n < budget) begin tick(); n++; end
    check(name, a_ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int lat, cs_at, n;
  logic [AW-1:0] seq [$];
  logic [AW-1:0] exp_seq [4];
  bit prev_cs;

  initial begin
    // reset state and first miss latency
    do_reset();
    check("rst_a_ok", a_ok, 1'b0);
    check("rst_a_data", a_data, 8'h00);
    check("rst_b_data", b_data, 8'h00);
    check("rst_slot_cs", slot_cs, 1'b0);
    check("rst_slot_addr", slot_addr, 17'h0);

    a_addr = 17'h01234; a_cs = 1'b1; delay = 2;
    cs_at = 0;
    for (lat = 1; lat <= 10; lat++) begin
      tick();
      if (slot_cs && cs_at == 0) cs_at = lat;
      if (a_ok) break;
    end
    check("p1_cs_cycle", cs_at, 1);
    check("p1_ok_cycle_4_or_5", (lat == 4 || lat == 5), 1'b1);
    check("p1_slot_addr", slot_addr, 17'h01234);
    check("p1_a_data", a_data, 8'h5A);
    check("p1_slot_cs_low", slot_cs, 1'b0);

    // repeated hit never touches the slot
    for (int i = 0; i < 20; i++) begin
      tick();
      check("p2_hit_ok", a_ok, 1'b1);
      check("p2_no_slot", slot_cs, 1'b0);
    end

    // both requesters missing continuously, slot_ok stuck high
    do_reset();
    a_addr = 17'h10; b_addr = 17'h20; a_cs = 1'b1; b_cs = 1'b1; force_ok = 1'b1;
    exp_seq[0] = 17'h10; exp_seq[1] = 17'h20; exp_seq[2] = 17'h11; exp_seq[3] = 17'h21;
    prev_cs = 1'b0; n = 0;
    while (n < 80 && !(seq.size() >= 4 && b_ok && b_addr == 17'h21)) begin
      tick(); n++;
      if (slot_cs && !prev_cs) seq.push_back(slot_addr);
      prev_cs = slot_cs;
      if (a_ok && a_addr == 17'h10) a_addr = 17'h11;
      if (b_ok && b_addr == 17'h20) b_addr = 17'h21;
    end
    force_ok = 1'b0;
    check("p3_grant_count", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("p3_grant_%0d", i), (i < seq.size()) ? seq[i] : 'x, exp_seq[i]);
    check("p3_a_data", a_data, 8'h6D);
    check("p3_b_data", b_data, 8'h5D);

    // requester B changes address mid-transaction
    a_cs = 1'b0; b_addr = 17'h300; delay = 4;
    wait_cs(1'b1, 10, "p4_issue");
    tick(); tick();
    b_addr = 17'h301;
    wait_cs(1'b0, 20, "p4_fill");
    check("p4_b_ok_stale", b_ok, 1'b0);
    check("p4_b_data_stale", b_data, 8'h7F);
    tick();
    check("p4_reissue_cs", slot_cs, 1'b1);
    check("p4_reissue_addr", slot_addr, 17'h301);
    n = 0;
    while (b_ok !== 1'b1 && n < 20) begin tick(); n++; end
    check("p4_b_ok", b_ok, 1'b1);
    check("p4_b_data", b_data, 8'h7E);

    // flush during WAIT
    b_cs = 1'b0; a_addr = 17'h40; a_cs = 1'b1; delay = 4;
    wait_cs(1'b1, 10, "p5_issue");
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_cs(1'b0, 20, "p5_fill");
    check("p5_a_ok_flushed", a_ok, 1'b0);
    check("p5_a_data", a_data, 8'h3C);
    tick();
    check("p5_reissue_cs", slot_cs, 1'b1);
    check("p5_reissue_addr", slot_addr, 17'h40);
    wait_a_ok(20, "p5_a_ok");

    // flush in the same cycle as slot_ok
    a_addr = 17'h41; delay = 2;
    wait_cs(1'b1, 10, "p5b_issue");
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("p5b_slot_cs", slot_cs, 1'b0);
    check("p5b_a_ok", a_ok, 1'b0);
    check("p5b_a_data", a_data, 8'h3D);
    wait_a_ok(20, "p5b_refill");

    // slot never answers
    a_addr = 17'h50; no_ok = 1'b1;
    wait_cs(1'b1, 10, "p6_issue");
`ifdef JTS16_PCMARB_TIMEOUT_EN
    n = 0;
    while (slot_cs && n < 100) begin tick(); n++; end
    check("p6_wait_cycles", n - 1, TIMEOUT);
    check("p6_a_ok", a_ok, 1'b1);
    check("p6_a_data", a_data, 8'hFF);
    a_addr = 17'h60;
    wait_cs(1'b1, 10, "p6_issue2");
    tick(); tick();
`else
    repeat (1000) tick();
    check("p6_cs_held", slot_cs, 1'b1);
    check("p6_addr_held", slot_addr, 17'h50);
    check("p6_a_ok", a_ok, 1'b0);
`endif

    // asynchronous reset in the middle of a transaction
    #2 rst_n = 1'b0;
    #1;
    check("p7_async_cs", slot_cs, 1'b0);
    check("p7_async_addr", slot_addr, 17'h0);
    check("p7_async_a_ok", a_ok, 1'b0);
    a_cs = 1'b0; no_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("p7_idle_after", slot_cs, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
